// File: rtl/rf_pkg.sv
// Shared types for the register-file writeback arbiter and its result FIFO.
package rf_pkg;

    localparam int REG_W          = 5;
    localparam int WORD_W         = 32;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_STARVE_MAX = 8;
    localparam int DEF_NREG       = 32;

    typedef logic [REG_W-1:0]  reg_idx_t;
    typedef logic [WORD_W-1:0] word_t;

    typedef struct packed {
        reg_idx_t wn;
        word_t    wd;
    } wb_entry_t;

    typedef enum logic {
        INT_PRIO,
        FPU_PRIO
    } arb_state_e;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_INT,
        WB_FPU
    } wb_src_e;

    // Register 0 is hardwired to zero, so any write aimed at it is dropped.
    function automatic logic is_r0(input reg_idx_t r);
        return r == '0;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Core-side bus of the writeback arbiter: integer writeback, decode sources,
// FPU issue/result handshake and the register-file write port.
interface regfile_wb_arbiter_if;
    import rf_pkg::*;

    logic     int_we;
    reg_idx_t int_wn;
    word_t    int_wd;
    reg_idx_t rs;
    reg_idx_t rt;
    logic     fpu_issue;
    reg_idx_t fpu_issue_wn;
    logic     fpu_valid;
    reg_idx_t fpu_wn;
    word_t    fpu_wd;
    logic     fpu_ready;
    logic     rf_we;
    reg_idx_t rf_wn;
    word_t    rf_wd;
    logic     stall;

    // Core / FPU side
    modport master (
        output int_we, int_wn, int_wd, rs, rt,
        output fpu_issue, fpu_issue_wn, fpu_valid, fpu_wn, fpu_wd,
        input  fpu_ready, rf_we, rf_wn, rf_wd, stall
    );

    // Arbiter side
    modport slave (
        input  int_we, int_wn, int_wd, rs, rt,
        input  fpu_issue, fpu_issue_wn, fpu_valid, fpu_wn, fpu_wd,
        output fpu_ready, rf_we, rf_wn, rf_wd, stall
    );

endinterface

// File: rtl/wb_fifo.sv
// Small synchronous FIFO buffering FPU results until the write port is free.
// The head is visible combinationally so it can be written in the same cycle.
module wb_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  wb_entry_t push_data,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output wb_entry_t head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem[rd_ptr_q];
    // A full FIFO never takes a push, even if it pops in the same cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Next pointers/count; depth is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents need no reset since the count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbiter for the single register-file write port shared by the integer
// datapath and the FPU. Tracks in-flight FPU destinations in a scoreboard,
// stalls the core on hazards against them, and forces an FPU slot after the
// buffered head has lost the port STARVE_MAX times in a row.
module regfile_wb_arbiter
    import rf_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int STARVE_MAX = DEF_STARVE_MAX,
    parameter int NREG       = DEF_NREG
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);

    localparam int ST_W = $clog2(STARVE_MAX + 1);

    arb_state_e      state_q, state_d;
    logic [ST_W-1:0] starve_q, starve_d;
    logic [NREG-1:0] sb_q, sb_d;

    logic      fifo_full;
    logic      fifo_empty;
    logic      fifo_push;
    logic      fifo_pop;
    wb_entry_t fifo_head;
    wb_entry_t fifo_in;
    logic      hazard;
    wb_src_e   wb_src;
    logic      rf_we_c;
    reg_idx_t  rf_wn_c;
    word_t     rf_wd_c;

    assign fifo_in   = '{wn: bus.fpu_wn, wd: bus.fpu_wd};
    assign fifo_push = bus.fpu_valid & ~fifo_full & ~rst;
    assign fifo_pop  = (wb_src == WB_FPU);

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    // A pending bit stays visible through the cycle its result is written.
    assign hazard = sb_q[bus.rs] | sb_q[bus.rt] | (bus.int_we & sb_q[bus.int_wn]);

    // Port arbitration and next state / starvation count.
    always_comb begin
        wb_src   = WB_NONE;
        state_d  = state_q;
        starve_d = starve_q;
        case (state_q)
            INT_PRIO: begin
                if (bus.int_we && !hazard) begin
                    wb_src = WB_INT;
                    if (!fifo_empty) begin
                        starve_d = starve_q + ST_W'(1);
                    end
                end else if (!fifo_empty) begin
                    wb_src   = WB_FPU;
                    starve_d = '0;
                end
                if (starve_d == ST_W'(STARVE_MAX)) begin
                    state_d = FPU_PRIO;
                end
            end
            FPU_PRIO: begin
                if (!fifo_empty) begin
                    wb_src = WB_FPU;
                end
                state_d  = INT_PRIO;
                starve_d = '0;
            end
            default: begin
                state_d  = INT_PRIO;
                starve_d = '0;
            end
        endcase
        // Nothing reaches the register file while reset is held.
        if (rst) begin
            wb_src = WB_NONE;
        end
    end

    // Scoreboard update: a new issue outranks a same-index clear.
    always_comb begin
        sb_d = sb_q;
        if (fifo_pop) begin
            sb_d[fifo_head.wn] = 1'b0;
        end
        if (bus.fpu_issue) begin
            sb_d[bus.fpu_issue_wn] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    // Write-port mux; idle port drives zero index/data.
    always_comb begin
        rf_we_c = 1'b0;
        rf_wn_c = '0;
        rf_wd_c = '0;
        case (wb_src)
            WB_INT: begin
                rf_we_c = ~is_r0(bus.int_wn);
                rf_wn_c = bus.int_wn;
                rf_wd_c = bus.int_wd;
            end
            WB_FPU: begin
                rf_we_c = ~is_r0(fifo_head.wn);
                rf_wn_c = fifo_head.wn;
                rf_wd_c = fifo_head.wd;
            end
            default: begin
                rf_we_c = 1'b0;
            end
        endcase
    end

    // Arbiter FSM, starvation counter and scoreboard registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= INT_PRIO;
            starve_q <= '0;
            sb_q     <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            sb_q     <= sb_d;
        end
    end

    assign bus.rf_we     = rf_we_c;
    assign bus.rf_wn     = rf_wn_c;
    assign bus.rf_wd     = rf_wd_c;
    assign bus.stall     = ~rst & (hazard | (state_q == FPU_PRIO));
    assign bus.fpu_ready = rst | ~fifo_full;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: every expected register-file write
// is queued when its stimulus is driven and matched when the port fires.
module tb_regfile_wb_arbiter;
    import rf_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter #(
        .FIFO_DEPTH (4),
        .STARVE_MAX (8),
        .NREG       (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int        total = 0;
    int        bad   = 0;
    wb_entry_t exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic expect_wr(input reg_idx_t wn, input word_t wd);
        exp_q.push_back('{wn: wn, wd: wd});
    endtask

    task automatic check_q(input string tag);
        check({tag, "_pending_writes"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic idle();
        bus.int_we       = 1'b0;
        bus.int_wn       = '0;
        bus.int_wd       = '0;
        bus.rs           = '0;
        bus.rt           = '0;
        bus.fpu_issue    = 1'b0;
        bus.fpu_issue_wn = '0;
        bus.fpu_valid    = 1'b0;
        bus.fpu_wn       = '0;
        bus.fpu_wd       = '0;
    endtask

    // Integer traffic on r2 with sources r1 that never hazard.
    task automatic int_base(input word_t wd);
        idle();
        bus.int_we = 1'b1;
        bus.int_wn = 5'd2;
        bus.int_wd = wd;
        bus.rs     = 5'd1;
        bus.rt     = 5'd1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: each write on the port must match the queue head.
    always @(negedge clk) begin : monitor
        wb_entry_t e;
        if (bus.rf_we) begin
            $display("wb r%0d = 0x%08h", bus.rf_wn, bus.rf_wd);
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("wr_wn", 32'(bus.rf_wn), 32'(e.wn));
                check("wr_wd", bus.rf_wd, e.wd);
            end
        end
    end

    initial begin
        int k;
        idle();
        rst = 1'b1;

        // 1. reset state, then an immediate integer write
        for (int c = 0; c < 2; c++) begin
            sample();
            check("rst_rf_we", 32'(bus.rf_we), 32'd0);
            check("rst_stall", 32'(bus.stall), 32'd0);
            check("rst_fpu_ready", 32'(bus.fpu_ready), 32'd1);
            check("rst_rf_wn", 32'(bus.rf_wn), 32'd0);
            next();
        end
        rst = 1'b0;
        idle();
        bus.int_we = 1'b1;
        bus.int_wn = 5'd5;
        bus.int_wd = 32'h0000_1234;
        expect_wr(5'd5, 32'h0000_1234);
        sample();
        check("t1_rf_we", 32'(bus.rf_we), 32'd1);
        next();
        idle();
        check_q("t1");

        // 2. FPU path with one-cycle latency, then scoreboard clear
        bus.fpu_issue    = 1'b1;
        bus.fpu_issue_wn = 5'd8;
        sample();
        check("t2_issue_stall", 32'(bus.stall), 32'd0);
        next();
        idle();
        bus.fpu_valid = 1'b1;
        bus.fpu_wn    = 5'd8;
        bus.fpu_wd    = 32'h3F80_0000;
        bus.rs        = 5'd8;
        sample();
        check("t2_ready", 32'(bus.fpu_ready), 32'd1);
        check("t2_no_bypass", 32'(bus.rf_we), 32'd0);
        check("t2_pending_stall", 32'(bus.stall), 32'd1);
        next();
        idle();
        bus.rs = 5'd8;
        expect_wr(5'd8, 32'h3F80_0000);
        sample();
        check("t2_wr_we", 32'(bus.rf_we), 32'd1);
        next();
        idle();
        bus.rs = 5'd8;
        sample();
        check("t2_sb_cleared", 32'(bus.stall), 32'd0);
        next();
        idle();
        check_q("t2");

        // 3. RAW hazard holds stall and suppresses the integer write
        bus.fpu_issue    = 1'b1;
        bus.fpu_issue_wn = 5'd9;
        next();
        for (int c = 0; c < 6; c++) begin
            idle();
            bus.rs     = 5'd9;
            bus.int_we = 1'b1;
            bus.int_wn = 5'd3;
            bus.int_wd = 32'h0000_0033;
            if (c == 3) begin
                bus.fpu_valid = 1'b1;
                bus.fpu_wn    = 5'd9;
                bus.fpu_wd    = 32'h0000_0099;
            end
            if (c == 4) expect_wr(5'd9, 32'h0000_0099);
            if (c == 5) expect_wr(5'd3, 32'h0000_0033);
            sample();
            check($sformatf("t3_stall_c%0d", c), 32'(bus.stall), (c < 5) ? 32'd1 : 32'd0);
            next();
        end
        idle();
        check_q("t3");

        // 4. starvation: 8 integer wins, one forced FPU slot, integer resumes
        k = 0;
        for (int c = 0; c < 11; c++) begin
            int_base(32'h100 + 32'(k));
            if (c == 0) begin
                bus.fpu_valid = 1'b1;
                bus.fpu_wn    = 5'd20;
                bus.fpu_wd    = 32'hA5A5_A5A5;
            end
            if (c == 9) expect_wr(5'd20, 32'hA5A5_A5A5);
            else        expect_wr(5'd2, 32'h100 + 32'(k));
            sample();
            check($sformatf("t4_stall_c%0d", c), 32'(bus.stall), (c == 9) ? 32'd1 : 32'd0);
            next();
            if (c != 9) k++;
        end
        idle();
        check_q("t4");

        // 5. FIFO full: ready drops after the 4th result, 5th waits for a pop
        k = 0;
        for (int c = 0; c < 11; c++) begin
            int_base(32'h200 + 32'(k));
            bus.fpu_valid = 1'b1;
            bus.fpu_wn    = (c < 4) ? reg_idx_t'(10 + c) : 5'd14;
            bus.fpu_wd    = (c < 4) ? 32'h5000 + 32'(c) : 32'h5004;
            if (c == 9) expect_wr(5'd10, 32'h5000);
            else        expect_wr(5'd2, 32'h200 + 32'(k));
            sample();
            check($sformatf("t5_ready_c%0d", c), 32'(bus.fpu_ready),
                  (c < 4 || c == 10) ? 32'd1 : 32'd0);
            check($sformatf("t5_stall_c%0d", c), 32'(bus.stall), (c == 9) ? 32'd1 : 32'd0);
            next();
            if (c != 9) k++;
        end
        for (int c = 1; c < 5; c++) begin
            idle();
            expect_wr(reg_idx_t'(10 + c), 32'h5000 + 32'(c));
            sample();
            next();
        end
        idle();
        sample();
        check("t5_drained_ready", 32'(bus.fpu_ready), 32'd1);
        next();
        check_q("t5");

        // 6a. writes to r0 are dropped but the FIFO entry is consumed
        idle();
        bus.fpu_valid = 1'b1;
        bus.fpu_wn    = 5'd0;
        bus.fpu_wd    = 32'hDEAD_BEEF;
        sample();
        next();
        idle();
        sample();
        check("t6_r0_fpu_we", 32'(bus.rf_we), 32'd0);
        next();
        idle();
        bus.fpu_valid = 1'b1;
        bus.fpu_wn    = 5'd15;
        bus.fpu_wd    = 32'h0000_1515;
        sample();
        next();
        idle();
        expect_wr(5'd15, 32'h0000_1515);
        sample();
        check("t6_after_r0_wn", 32'(bus.rf_wn), 32'd15);
        next();
        idle();
        bus.int_we = 1'b1;
        bus.int_wn = 5'd0;
        bus.int_wd = 32'h0000_00EE;
        sample();
        check("t6_r0_int_we", 32'(bus.rf_we), 32'd0);
        next();
        idle();
        check_q("t6a");

        // 6b. reset with three results queued discards them and their pending bits
        for (int c = 0; c < 6; c++) begin
            int_base(32'h600 + 32'(c));
            if (c < 3) begin
                bus.fpu_issue    = 1'b1;
                bus.fpu_issue_wn = reg_idx_t'(16 + c);
            end else begin
                bus.fpu_valid = 1'b1;
                bus.fpu_wn    = reg_idx_t'(16 + c - 3);
                bus.fpu_wd    = 32'h700 + 32'(c);
            end
            expect_wr(5'd2, 32'h600 + 32'(c));
            sample();
            next();
        end
        int_base(32'h0000_0666);
        bus.fpu_valid    = 1'b1;
        bus.fpu_wn       = 5'd19;
        bus.fpu_wd       = 32'h0000_0719;
        bus.fpu_issue    = 1'b1;
        bus.fpu_issue_wn = 5'd19;
        rst = 1'b1;
        sample();
        check("t6_rst_we", 32'(bus.rf_we), 32'd0);
        check("t6_rst_stall", 32'(bus.stall), 32'd0);
        check("t6_rst_ready", 32'(bus.fpu_ready), 32'd1);
        next();
        rst = 1'b0;
        idle();
        bus.rs = 5'd16;
        bus.rt = 5'd17;
        sample();
        check("t6_post_stall", 32'(bus.stall), 32'd0);
        check("t6_post_we", 32'(bus.rf_we), 32'd0);
        check("t6_post_ready", 32'(bus.fpu_ready), 32'd1);
        next();
        idle();
        bus.rs     = 5'd19;
        bus.int_we = 1'b1;
        bus.int_wn = 5'd18;
        bus.int_wd = 32'h0000_1818;
        expect_wr(5'd18, 32'h0000_1818);
        sample();
        check("t6_post_int_stall", 32'(bus.stall), 32'd0);
        next();
        idle();
        for (int c = 0; c < 3; c++) begin
            sample();
            next();
        end
        check_q("t6b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
